// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: packs decoded instruction requests into 32-bit
// MIPS words and streams them into consecutive instruction-memory addresses.
//
//  state  | meaning
//  -------+-----------------------------------------------------------------
//  S_IDLE | waiting for start; requests are not accepted
//  S_LOAD | accepting requests; each accept produces one write next cycle
module instr_encoder_loader #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [3:0]                   in_opc,
  input  logic [4:0]                   in_rs,
  input  logic [4:0]                   in_rt,
  input  logic [4:0]                   in_rd,
  input  logic [4:0]                   in_shamt,
  input  logic [15:0]                  in_imm,
  output logic                         imem_we,
  output logic [31:0]                  imem_addr,
  output logic [31:0]                  imem_wdata,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [$clog2(DEPTH+1)-1:0]   word_count
);

  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {S_IDLE, S_LOAD} state_t;

  state_t        r_state;
  logic          r_imem_we;
  logic [31:0]   r_imem_addr;
  logic [31:0]   r_imem_wdata;
  logic          r_done;
  logic          r_err;
  logic [CW-1:0] r_word_count;
  logic          w_last_slot;
  logic [31:0]   w_enc;

  // Pack one request into its MIPS word; op/func match the Controller decode.
  function automatic logic [31:0] f_encode(
    input logic [3:0]  opc,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [15:0] imm
  );
    logic [5:0]  func;
    logic [5:0]  op;
    logic [31:0] word;
    func = 6'b000000;
    op   = 6'b000000;
    word = 32'h0;
    case (opc)
      4'd0:  func = 6'b100000;
      4'd1:  func = 6'b100010;
      4'd2:  func = 6'b100100;
      4'd3:  func = 6'b100101;
      4'd4:  func = 6'b101010;
      4'd5:  func = 6'b000000;
      4'd6:  func = 6'b000010;
      4'd7:  func = 6'b000110;
      4'd8:  func = 6'b100001;
      4'd9:  func = 6'b100000;
      4'd10: func = 6'b000010;
      4'd11: op   = 6'b001000;
      4'd12: op   = 6'b001101;
      4'd13: op   = 6'b100011;
      4'd14: op   = 6'b101011;
      default: op = 6'b000101;
    endcase
    if (opc <= 4'd7) begin
      // Shifts by immediate carry shamt and leave rs unused (zeroed).
      if (opc == 4'd5 || opc == 4'd6)
        word = {6'b000000, 5'd0, rt, rd, shamt, func};
      else
        word = {6'b000000, rs, rt, rd, 5'd0, func};
    end else if (opc <= 4'd10) begin
      word = {6'b011100, rs, rt, rd, 5'd0, func};
    end else begin
      word = {op, rs, rt, imm};
    end
    return word;
  endfunction

  assign w_enc       = f_encode(in_opc, in_rs, in_rt, in_rd, in_shamt, in_imm);
  assign w_last_slot = (r_word_count == CW'(DEPTH-1));

  // Handshake and status follow the state directly.
  assign in_ready   = (r_state == S_LOAD);
  assign busy       = (r_state == S_LOAD);
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign done       = r_done;
  assign err        = r_err;
  assign word_count = r_word_count;

  // Load FSM: registers each accepted request as a write one cycle later.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= S_IDLE;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= 32'h0;
      r_imem_wdata <= 32'h0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_imem_we <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_LOAD;
            r_word_count <= '0;
            r_err        <= 1'b0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            r_imem_we    <= 1'b1;
            r_imem_addr  <= BASE_ADDR + (32'(r_word_count) << 2);
            r_imem_wdata <= w_enc;
            r_word_count <= r_word_count + CW'(1);
            // Final word either by request or because the buffer is full;
            // a full buffer without in_last is an overflow.
            if (in_last || w_last_slot) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
              if (!in_last)
                r_err <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: behavioural model + per-cycle compare,
// plus literal checks of known encodings and write timing.
module tb_instr_encoder_loader;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          CW    = $clog2(DEPTH+1);

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [3:0]    in_opc = 4'd0;
  logic [4:0]    in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0, in_shamt = 5'd0;
  logic [15:0]   in_imm = 16'd0;
  logic          in_ready, imem_we, busy, done, err;
  logic [31:0]   imem_addr, imem_wdata;
  logic [CW-1:0] word_count;

  instr_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .in_opc(in_opc), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoding, one line per mnemonic.
  function automatic logic [31:0] m_enc(input logic [3:0] opc, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm);
    case (opc)
      4'd0:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      4'd1:  return {6'h00, rs, rt, rd, 5'd0, 6'h22};
      4'd2:  return {6'h00, rs, rt, rd, 5'd0, 6'h24};
      4'd3:  return {6'h00, rs, rt, rd, 5'd0, 6'h25};
      4'd4:  return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      4'd5:  return {6'h00, 5'd0, rt, rd, sh, 6'h00};
      4'd6:  return {6'h00, 5'd0, rt, rd, sh, 6'h02};
      4'd7:  return {6'h00, rs, rt, rd, 5'd0, 6'h06};
      4'd8:  return {6'h1C, rs, rt, rd, 5'd0, 6'h21};
      4'd9:  return {6'h1C, rs, rt, rd, 5'd0, 6'h20};
      4'd10: return {6'h1C, rs, rt, rd, 5'd0, 6'h02};
      4'd11: return {6'h08, rs, rt, imm};
      4'd12: return {6'h0D, rs, rt, imm};
      4'd13: return {6'h23, rs, rt, imm};
      4'd14: return {6'h2B, rs, rt, imm};
      default: return {6'h05, rs, rt, imm};
    endcase
  endfunction

  // Behavioural model: what the outputs must be during the cycle after each edge.
  bit          m_load = 0, m_err = 0, e_we = 0, e_done = 0;
  int          m_cnt = 0;
  int          cyc = 0;
  logic [31:0] e_addr = 32'h0, e_data = 32'h0;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_load = 0; m_err = 0; e_we = 0; e_done = 0; m_cnt = 0;
      e_addr = 32'h0; e_data = 32'h0;
    end else begin
      cyc++;
      e_we = 0;
      e_done = 0;
      if (!m_load) begin
        if (start) begin
          m_load = 1; m_cnt = 0; m_err = 0;
        end
      end else if (in_valid) begin
        e_we   = 1;
        e_addr = BASE + 32'(4 * m_cnt);
        e_data = m_enc(in_opc, in_rs, in_rt, in_rd, in_shamt, in_imm);
        m_cnt++;
        if (in_last || m_cnt == DEPTH) begin
          e_done = 1;
          m_load = 0;
          if (!in_last) m_err = 1;
        end
      end
    end
  end

  logic [31:0] lq_addr[$], lq_data[$];
  bit          lq_done[$];
  int          lq_cyc[$];

  // Per-cycle compare against the model, plus a log of observed writes.
  always @(negedge Clk) begin
    chk("in_ready", 32'(in_ready), 32'(m_load));
    chk("busy", 32'(busy), 32'(m_load));
    chk("imem_we", 32'(imem_we), 32'(e_we));
    chk("imem_addr", imem_addr, e_addr);
    chk("imem_wdata", imem_wdata, e_data);
    chk("done", 32'(done), 32'(e_done));
    chk("err", 32'(err), 32'(m_err));
    chk("word_count", 32'(word_count), 32'(m_cnt));
    if (imem_we === 1'b1) begin
      lq_addr.push_back(imem_addr);
      lq_data.push_back(imem_wdata);
      lq_done.push_back(done);
      lq_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] opc, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
      input logic last, output bit acc);
    in_opc = opc; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm;
    in_last = last;
    in_valid = 1'b1;
    acc = in_ready;
    tick(1);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic clear_log();
    lq_addr.delete(); lq_data.delete(); lq_done.delete(); lq_cyc.delete();
  endtask

  bit acc;
  bit accs[5];

  initial begin
    // Pin the reference encoder itself.
    chk("model_add", m_enc(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0), 32'h00221820);
    chk("model_sll", m_enc(4'd5, 5'd7, 5'd2, 5'd5, 5'd3, 16'd0), 32'h000228C0);

    // Reset values.
    tick(3);
    chk("rst_we", 32'(imem_we), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wc", 32'(word_count), 32'h0);
    Rst_n = 1'b1;
    tick(2);

    // Single ADD with last.
    clear_log();
    pulse_start();
    send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 1'b1, acc);
    chk("add_acc", 32'(acc), 32'h1);
    chk("add_we", 32'(imem_we), 32'h1);
    chk("add_done", 32'(done), 32'h1);
    chk("add_addr", imem_addr, 32'h100);
    chk("add_data", imem_wdata, 32'h00221820);
    tick(1);
    chk("add_done_pulse", 32'(done), 32'h0);
    chk("add_idle", 32'(busy), 32'h0);

    // Back-to-back I-type program.
    clear_log();
    pulse_start();
    send(4'd11, 5'd0, 5'd2, 5'd0, 5'd0, 16'h0005, 1'b0, acc);
    send(4'd13, 5'd1, 5'd4, 5'd0, 5'd0, 16'h0008, 1'b0, acc);
    send(4'd15, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 1'b1, acc);
    tick(2);
    chk("b2b_n", 32'(lq_addr.size()), 32'd3);
    if (lq_addr.size() == 3) begin
      chk("b2b_d0", lq_data[0], 32'h20020005);
      chk("b2b_d1", lq_data[1], 32'h8C240008);
      chk("b2b_d2", lq_data[2], 32'h1422FFFF);
      chk("b2b_a2", lq_addr[2], 32'h108);
      chk("b2b_cyc", 32'(lq_cyc[2] - lq_cyc[0]), 32'd2);
      chk("b2b_done_last", 32'(lq_done[2]), 32'h1);
    end
    chk("b2b_wc", 32'(word_count), 32'd3);

    // Shift field zeroing and Special2.
    clear_log();
    pulse_start();
    send(4'd5, 5'd7, 5'd2, 5'd5, 5'd3, 16'h1234, 1'b0, acc);
    send(4'd10, 5'd1, 5'd2, 5'd3, 5'd9, 16'h0, 1'b1, acc);
    tick(1);
    chk("sh_n", 32'(lq_data.size()), 32'd2);
    if (lq_data.size() == 2) begin
      chk("sll_data", lq_data[0], 32'h000228C0);
      chk("mul_data", lq_data[1], 32'h70221802);
    end

    // Gaps, with a start pulse during LOAD that must be ignored.
    clear_log();
    pulse_start();
    send(4'd1, 5'd4, 5'd5, 5'd6, 5'd2, 16'h0, 1'b0, acc);
    tick(1);
    pulse_start();
    send(4'd9, 5'd3, 5'd8, 5'd9, 5'd0, 16'h0, 1'b0, acc);
    tick(1);
    send(4'd12, 5'd2, 5'd3, 5'd0, 5'd0, 16'hBEEF, 1'b1, acc);
    tick(1);
    chk("gap_n", 32'(lq_addr.size()), 32'd3);
    if (lq_addr.size() == 3) begin
      chk("gap_sub", lq_data[0], 32'h00853022);
      chk("gap_a1", lq_addr[1], 32'h104);
      chk("gap_a2", lq_addr[2], 32'h108);
      chk("gap_cyc", 32'(lq_cyc[1] - lq_cyc[0]), 32'd3);
    end
    chk("gap_wc", 32'(word_count), 32'd3);

    // Overflow: DEPTH requests without last, then one more.
    clear_log();
    pulse_start();
    for (int i = 0; i < 5; i++)
      send(4'd3, 5'(i), 5'(i + 1), 5'(i + 2), 5'd0, 16'h0, 1'b0, accs[i]);
    for (int i = 0; i < 4; i++)
      chk($sformatf("ovf_acc%0d", i), 32'(accs[i]), 32'h1);
    chk("ovf_5th_rejected", 32'(accs[4]), 32'h0);
    chk("ovf_n", 32'(lq_addr.size()), 32'd4);
    if (lq_addr.size() == 4) begin
      chk("ovf_done", 32'(lq_done[3]), 32'h1);
      chk("ovf_a3", lq_addr[3], 32'h10C);
    end
    chk("ovf_err", 32'(err), 32'h1);
    chk("ovf_wc", 32'(word_count), 32'd4);
    pulse_start();
    chk("start_clr_err", 32'(err), 32'h0);
    chk("start_busy", 32'(busy), 32'h1);

    // Reset right after an accept: the write must not survive.
    clear_log();
    in_opc = 4'd0; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_last = 1'b1;
    in_valid = 1'b1;
    @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    #1;
    chk("rstmid_we", 32'(imem_we), 32'h0);
    chk("rstmid_done", 32'(done), 32'h0);
    chk("rstmid_data", imem_wdata, 32'h0);
    chk("rstmid_wc", 32'(word_count), 32'h0);
    chk("rstmid_ready", 32'(in_ready), 32'h0);
    tick(2);
    Rst_n = 1'b1;
    tick(2);
    chk("rstmid_nowrite", 32'(lq_addr.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
